// File: rtl/next_state_sequencer_if.sv
// Handshake/status bundle between the next-state sequencer and its datapath neighbours.
// master: the sequencer side; slave: IR / condition tester / memory / control decoder side.
interface next_state_sequencer_if;
  logic        run;
  logic        moc;
  logic        cond_true;
  logic [31:0] ir;
  logic [6:0]  state;
  logic        mem_wait;
  logic        instr_done;
  logic        mem_err;
  logic        halted;

  modport master (
    input  run, moc, cond_true, ir,
    output state, mem_wait, instr_done, mem_err, halted
  );

  modport slave (
    output run, moc, cond_true, ir,
    input  state, mem_wait, instr_done, mem_err, halted
  );
endinterface

// File: rtl/next_state_sequencer.sv
// CPU datapath sequencer: state register plus next-state logic for fetch/decode/execute.
// Optional feature: define UNDEF_TRAP_EN to send undefined opcodes to trap state 63.
module next_state_sequencer #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  next_state_sequencer_if.master bus
);

  typedef enum logic [6:0] {
    StIdle       = 7'd0,
    StFetch      = 7'd1,
    StPcInc      = 7'd2,
    StIrLoad     = 7'd3,
    StDecode     = 7'd4,
    StDpReg      = 7'd5,
    StDpImm      = 7'd6,
    StBranch     = 7'd7,
    StBranchLink = 7'd8,
    StLdImm      = 7'd33,
    StLdAddr     = 7'd34,
    StLdWait     = 7'd35,
    StLdData     = 7'd36,
    StLdWbImm    = 7'd38,
    StStWbImm    = 7'd39,
    StStImm      = 7'd40,
    StStAddr     = 7'd41,
    StStWait     = 7'd42,
    StLdReg      = 7'd46,
    StStReg      = 7'd47,
    StLdWbReg    = 7'd48,
    StStWbReg    = 7'd49,
    StTrap       = 7'd63
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic        in_wait;
  logic        timeout;
  logic        wb;
  logic        unused_ir;

  assign unused_ir = ^{bus.ir[31:28], bus.ir[19:0]};

  assign in_wait = (state_q == StIrLoad) || (state_q == StLdWait) || (state_q == StStWait);
  // Write-back for pre-indexed with W set, or any post-indexed access.
  assign wb      = bus.ir[21] | ~bus.ir[24];
  // Fires on the WAIT_LIMIT-th consecutive waiting cycle; a same-cycle moc takes priority.
  assign timeout = (WAIT_LIMIT != 0) && in_wait && !bus.moc &&
                   ((wait_cnt_q + 32'd1) == WAIT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.run) state_d = StFetch;
      StFetch:  state_d = StPcInc;
      StPcInc:  state_d = StIrLoad;
      StIrLoad: if (bus.moc) state_d = StDecode;
      StDecode: begin
        if (!bus.cond_true) begin
          state_d = StFetch;
        end else begin
          case (bus.ir[27:25])
            3'b000:  state_d = StDpReg;
            3'b001:  state_d = StDpImm;
            3'b010:  state_d = bus.ir[20] ? StLdImm : StStImm;
            3'b011:  state_d = bus.ir[20] ? StLdReg : StStReg;
            3'b101:  state_d = bus.ir[24] ? StBranchLink : StBranch;
            default: begin
`ifdef UNDEF_TRAP_EN
              state_d = StTrap;
`else
              state_d = StFetch;
`endif
            end
          endcase
        end
      end
      StDpReg, StDpImm, StBranch, StBranchLink: state_d = StFetch;
      StLdImm, StLdReg: state_d = StLdAddr;
      StLdAddr: state_d = StLdWait;
      StLdWait: if (bus.moc) state_d = StLdData;
      StLdData: begin
        if (wb) state_d = bus.ir[25] ? StLdWbReg : StLdWbImm;
        else    state_d = StFetch;
      end
      StStImm, StStReg: state_d = StStAddr;
      StStAddr: state_d = StStWait;
      StStWait: begin
        if (bus.moc) begin
          if (wb) state_d = bus.ir[25] ? StStWbReg : StStWbImm;
          else    state_d = StFetch;
        end
      end
      StLdWbImm, StStWbImm, StLdWbReg, StStWbReg: state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StIdle;
    endcase
    if (timeout) state_d = StIdle;
  end

  always_comb begin
    wait_cnt_d = '0;
    if ((WAIT_LIMIT != 0) && in_wait && !bus.moc) wait_cnt_d = wait_cnt_q + 32'd1;
    mem_err_d = mem_err_q | timeout;
  end

  always_comb begin
    bus.state      = state_q;
    bus.mem_wait   = in_wait & ~bus.moc;
    bus.instr_done = (state_d == StFetch) && (state_q != StIdle) && (state_q != StFetch);
    bus.mem_err    = mem_err_q;
    bus.halted     = (state_q == StTrap);
  end

endmodule

// File: tb/tb_next_state_sequencer.sv
// Bench for next_state_sequencer: builds expected per-cycle state traces from instruction-level
// rules, replays them as stimulus and checks every output each cycle.
module tb_next_state_sequencer;

  localparam int unsigned Limit = 4;

  logic clk = 1'b0;
  logic rst_n;

  next_state_sequencer_if bus ();

  next_state_sequencer #(.WAIT_LIMIT(Limit)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    bit          moc;
    bit          run;
    bit          cond;
    logic [31:0] ir;
    bit          err;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  bit          m_err;
  logic [31:0] cur_ir;
  bit          cur_cond;
  bit          cur_noise;
  bit          exp_valid;
  ent_t        exp_e;
  bit          exp_has_next;
  int          exp_next;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  function automatic bit is_wait(int st);
    return (st == 3) || (st == 35) || (st == 42);
  endfunction

  // Noisy instructions raise moc and run wherever they must be ignored.
  task automatic push(int st, bit moc = 1'b0, bit run = 1'b0);
    ent_t e;
    e.st   = st;
    e.ir   = cur_ir;
    e.cond = cur_cond;
    e.err  = m_err;
    if (cur_noise && st != 0 && !is_wait(st)) begin
      e.moc = 1'b1;
      e.run = 1'b1;
    end else begin
      e.moc = moc;
      e.run = run;
    end
    q.push_back(e);
  endtask

  task automatic gen_wait(int st, int lat, output bit ok);
    ok = 1'b1;
    for (int k = 0; k < lat; k++) begin
      push(st, 1'b0);
      if (Limit != 0 && k + 1 == int'(Limit)) begin
        m_err = 1'b1;
        push(0);
        ok = 1'b0;
        return;
      end
    end
    push(st, 1'b1);
  endtask

  task automatic gen_instr(logic [31:0] ir, bit cond, int lat_f, int lat_d, bit noise);
    bit ok;
    bit wb;
    cur_ir    = ir;
    cur_cond  = cond;
    cur_noise = noise;
    push(1);
    push(2);
    gen_wait(3, lat_f, ok);
    if (!ok) return;
    push(4);
    if (!cond) return;
    wb = ir[21] | ~ir[24];
    case (ir[27:25])
      3'b000: push(5);
      3'b001: push(6);
      3'b101: push(ir[24] ? 8 : 7);
      3'b010, 3'b011: begin
        if (ir[20]) begin
          push(ir[25] ? 46 : 33);
          push(34);
          gen_wait(35, lat_d, ok);
          if (!ok) return;
          push(36);
          if (wb) push(ir[25] ? 48 : 38);
        end else begin
          push(ir[25] ? 47 : 40);
          push(41);
          gen_wait(42, lat_d, ok);
          if (!ok) return;
          if (wb) push(ir[25] ? 49 : 39);
        end
      end
      default: begin
`ifdef UNDEF_TRAP_EN
        push(63);
`endif
      end
    endcase
  endtask

  task automatic pin_seq(string nm, int base, int seq[$]);
    for (int k = 0; k < seq.size(); k++) chk(nm, 32'(q[base+k].st), 32'(seq[k]));
  endtask

  task automatic play();
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      bus.run       = q[i].run;
      bus.moc       = q[i].moc;
      bus.cond_true = q[i].cond;
      bus.ir        = q[i].ir;
      exp_e         = q[i];
      exp_has_next  = (i + 1 < q.size());
      if (exp_has_next) exp_next = q[i+1].st;
      exp_valid     = 1'b1;
    end
    @(negedge clk);
    exp_valid = 1'b0;
    q.delete();
  endtask

  always @(negedge clk) begin
    #2;
    if (exp_valid) begin
      chk("state", 32'(bus.state), 32'(exp_e.st));
      chk("mem_wait", 32'(bus.mem_wait), 32'(is_wait(exp_e.st) && !exp_e.moc));
      if (exp_has_next)
        chk("instr_done", 32'(bus.instr_done), 32'(exp_next == 1 && exp_e.st > 1));
      chk("mem_err", 32'(bus.mem_err), 32'(exp_e.err));
      chk("halted", 32'(bus.halted), 32'(exp_e.st == 63));
    end
  end

  initial begin
    int b;
    int sq[$];
    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.moc       = 1'b0;
    bus.cond_true = 1'b0;
    bus.ir        = '0;
    exp_valid     = 1'b0;
    exp_has_next  = 1'b0;
    exp_next      = 0;
    m_err         = 1'b0;
    cur_ir        = '0;
    cur_cond      = 1'b0;
    cur_noise     = 1'b0;
    #12;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_mem_wait", 32'(bus.mem_wait), 0);
    chk("rst_instr_done", 32'(bus.instr_done), 0);
    chk("rst_mem_err", 32'(bus.mem_err), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    @(negedge clk);
    rst_n = 1'b1;

    push(0);
    push(0);
    push(0, 1'b0, 1'b1);
    b = q.size();
    gen_instr(32'hE0810002, 1'b1, 2, 0, 1'b0);
    sq = '{1, 2, 3, 3, 3, 4, 5};
    pin_seq("model_dp_reg", b, sq);
    b = q.size();
    gen_instr(32'hE5912004, 1'b1, 0, 1, 1'b0);
    sq = '{1, 2, 3, 4, 33, 34, 35, 35, 36};
    pin_seq("model_ldr_imm", b, sq);
    b = q.size();
    gen_instr(32'hE7A12003, 1'b1, 0, 0, 1'b0);
    sq = '{1, 2, 3, 4, 47, 41, 42, 49};
    pin_seq("model_str_reg_wb", b, sq);
    gen_instr(32'hE7812003, 1'b1, 0, 2, 1'b0);
    gen_instr(32'hE6912003, 1'b1, 1, 0, 1'b1);
    gen_instr(32'hE5B12004, 1'b1, 0, 0, 1'b0);
    gen_instr(32'hE4812004, 1'b1, 0, 1, 1'b0);
    gen_instr(32'hE2800001, 1'b1, 0, 0, 1'b1);
    gen_instr(32'hEA000000, 1'b1, 0, 0, 1'b0);
    gen_instr(32'hEB000000, 1'b1, 0, 0, 1'b0);
    gen_instr(32'hE0810002, 1'b0, 0, 0, 1'b0);
    // moc arrives exactly on the limit cycle in both fetch and data waits
    gen_instr(32'hE5912004, 1'b1, 3, 3, 1'b0);
    b = q.size();
    gen_instr(32'hE0810002, 1'b1, 100, 0, 1'b0);
    sq = '{1, 2, 3, 3, 3, 3, 0};
    pin_seq("model_timeout", b, sq);
    push(0);
    push(0, 1'b0, 1'b1);
    cur_ir   = 32'hE5912004;
    cur_cond = 1'b1;
    push(1);
    push(2);
    push(3, 1'b1);
    push(4);
    push(33);
    push(34);
    push(35);
    push(35);
    play();

    #3;
    chk("pre_reset_state", 32'(bus.state), 35);
    chk("pre_reset_mem_err", 32'(bus.mem_err), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(bus.state), 0);
    chk("async_rst_mem_err", 32'(bus.mem_err), 0);
    m_err = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    bus.run = 1'b0;
    bus.moc = 1'b0;

    push(0, 1'b0, 1'b1);
    b = q.size();
    gen_instr(32'hEC000000, 1'b1, 0, 0, 1'b1);
`ifdef UNDEF_TRAP_EN
    sq = '{1, 2, 3, 4, 63};
    push(63);
    push(63);
`else
    sq = '{1, 2, 3, 4};
    gen_instr(32'hE8000000, 1'b1, 0, 0, 1'b0);
    gen_instr(32'hE2800001, 1'b1, 0, 0, 1'b0);
`endif
    pin_seq("model_undef", b, sq);
    play();

    #3;
`ifdef UNDEF_TRAP_EN
    chk("trap_held_state", 32'(bus.state), 63);
    chk("trap_halted", 32'(bus.halted), 1);
`else
    chk("nop_next_state", 32'(bus.state), 1);
    chk("nop_halted", 32'(bus.halted), 0);
`endif
    rst_n = 1'b0;
    #1;
    chk("final_rst_state", 32'(bus.state), 0);
    chk("final_rst_halted", 32'(bus.halted), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
